// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Instruction sequencer FSM. Fetches an instruction, latches its
//            opcode, dispatches to single-cycle, multi-cycle ALU, or illegal
//            handling, and pulses exec_done on retire.
// Config   : SEQ_HALT_EN - when defined, opcode 0111 enters a terminal HALT
//            state left only by reset; when undefined 0111 is illegal.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
  parameter int INSTR_W    = 16,
  parameter int OPC_W      = 4,
  parameter int ALU_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  output logic               fetch_req,
  output logic               ir_load,
  output logic [OPC_W-1:0]   opc_q,
  output logic [3:0]         state,
  output logic [3:0]         alu_phase,
  output logic               exec_done,
  output logic               illegal
);

  // State encoding
  localparam logic [3:0] S_IDLE   = 4'b0000;
  localparam logic [3:0] S_FETCH  = 4'b1111;
  localparam logic [3:0] S_LATCH  = 4'b0001;
  localparam logic [3:0] S_DECODE = 4'b0010;
  localparam logic [3:0] S_LOAD   = 4'b0011;
  localparam logic [3:0] S_MOV    = 4'b0100;
  localparam logic [3:0] S_ALU    = 4'b0101;
  localparam logic [3:0] S_LDPC   = 4'b0110;
  localparam logic [3:0] S_BRANCH = 4'b0111;
  localparam logic [3:0] S_RETIRE = 4'b1000;
`ifdef SEQ_HALT_EN
  localparam logic [3:0] S_HALT   = 4'b1001;
`endif

  // Opcode encoding
  localparam logic [OPC_W-1:0] OP_LOAD   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_MOV    = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD    = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SUB    = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR    = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LDPC   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_BRANCH = OPC_W'(6);
`ifdef SEQ_HALT_EN
  localparam logic [OPC_W-1:0] OP_HALT   = OPC_W'(7);
`endif

  // Final ALU step index; the ALU state exits after this phase
  localparam logic [3:0] ALU_LAST = 4'(ALU_CYCLES - 1);

  logic [3:0]       state_q, state_d;
  logic [OPC_W-1:0] opc_d;
  logic [3:0]       alu_phase_q, alu_phase_d;
  logic             illegal_q, illegal_d;
  logic             decode_illegal;
`ifdef SEQ_HALT_EN
  logic             halt_seen_q, halt_seen_d;
`endif

  // Only the opcode field of the instruction is consumed here
  generate
    if (INSTR_W > OPC_W) begin : g_unused_instr
      logic unused_instr_bits;
      assign unused_instr_bits = ^instr[INSTR_W-OPC_W-1:0];
    end
  endgenerate

  // State and datapath registers; reset overrides every transition
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      opc_q       <= '0;
      alu_phase_q <= 4'd0;
      illegal_q   <= 1'b0;
`ifdef SEQ_HALT_EN
      halt_seen_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      opc_q       <= opc_d;
      alu_phase_q <= alu_phase_d;
      illegal_q   <= illegal_d;
`ifdef SEQ_HALT_EN
      halt_seen_q <= halt_seen_d;
`endif
    end
  end

  // Next-state logic from registered state, latched opcode, mem_ready, phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_LATCH;
      S_LATCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opc_q)
          OP_LOAD:                state_d = S_LOAD;
          OP_MOV:                 state_d = S_MOV;
          OP_ADD, OP_SUB, OP_XOR: state_d = S_ALU;
          OP_LDPC:                state_d = S_LDPC;
          OP_BRANCH:              state_d = S_BRANCH;
`ifdef SEQ_HALT_EN
          OP_HALT:                state_d = S_HALT;
`endif
          default:                state_d = S_RETIRE;
        endcase
      end
      S_LOAD, S_MOV, S_LDPC, S_BRANCH: state_d = S_RETIRE;
      S_ALU:    if (alu_phase_q == ALU_LAST) state_d = S_RETIRE;
      S_RETIRE: state_d = S_FETCH;
`ifdef SEQ_HALT_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // Opcode capture, ALU phase counter and sticky illegal flag
  always_comb begin
    opc_d = opc_q;
    if (state_q == S_LATCH) begin
      opc_d = instr[INSTR_W-1 -: OPC_W];
    end
    alu_phase_d = 4'd0;
    if ((state_q == S_ALU) && (alu_phase_q != ALU_LAST)) begin
      alu_phase_d = alu_phase_q + 4'd1;
    end
    // Any DECODE that falls through straight to RETIRE is an unknown opcode
    decode_illegal = (state_q == S_DECODE) && (state_d == S_RETIRE);
    illegal_d      = illegal_q | decode_illegal;
`ifdef SEQ_HALT_EN
    halt_seen_d = halt_seen_q | (state_q == S_HALT);
`endif
  end

  // Moore strobes decoded from state; HALT retires once on its first cycle
  always_comb begin
    fetch_req = (state_q == S_FETCH);
    ir_load   = (state_q == S_LATCH);
    exec_done = (state_q == S_RETIRE);
`ifdef SEQ_HALT_EN
    if ((state_q == S_HALT) && !halt_seen_q) begin
      exec_done = 1'b1;
    end
`endif
  end

  assign state     = state_q;
  assign alu_phase = alu_phase_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_sequencer
// Brief    : Directed self-checking bench for cpu_sequencer. Each issued
//            instruction pushes its expected retire (cycle, opcode, illegal)
//            into a scoreboard that a monitor pops on every exec_done pulse.
//            Honours SEQ_HALT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

  localparam int INSTR_W    = 16;
  localparam int OPC_W      = 4;
  localparam int ALU_CYCLES = 3;

  localparam logic [3:0] S_IDLE   = 4'b0000;
  localparam logic [3:0] S_FETCH  = 4'b1111;
  localparam logic [3:0] S_LATCH  = 4'b0001;
  localparam logic [3:0] S_DECODE = 4'b0010;
  localparam logic [3:0] S_ALU    = 4'b0101;
  localparam logic [3:0] S_RETIRE = 4'b1000;
  localparam logic [3:0] S_HALT   = 4'b1001;

  localparam int K_SINGLE = 0;
  localparam int K_ALU    = 1;
  localparam int K_ILL    = 2;
  localparam int K_HALT   = 3;

  logic               clk;
  logic               reset;
  logic [INSTR_W-1:0] instr;
  logic               mem_ready;
  logic               fetch_req;
  logic               ir_load;
  logic [OPC_W-1:0]   opc_q;
  logic [3:0]         state;
  logic [3:0]         alu_phase;
  logic               exec_done;
  logic               illegal;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic ill_model = 1'b0;

  typedef struct {
    string      tag;
    logic [3:0] opc;
    logic       ill;
    int         due;
  } exp_t;
  exp_t sb[$];

  cpu_sequencer #(
    .INSTR_W(INSTR_W),
    .OPC_W(OPC_W),
    .ALU_CYCLES(ALU_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instr(instr),
    .mem_ready(mem_ready),
    .fetch_req(fetch_req),
    .ir_load(ir_load),
    .opc_q(opc_q),
    .state(state),
    .alu_phase(alu_phase),
    .exec_done(exec_done),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every exec_done pulse must match the oldest issue
  always @(negedge clk) begin
    if (exec_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_exec_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_done_cycle"}, cyc, e.due);
        chk({e.tag, "_done_opc"}, opc_q, e.opc);
        chk({e.tag, "_done_illegal"}, illegal, e.ill);
      end
    end
  end

  function automatic int kind_of(input logic [3:0] o);
    case (o)
      4'd0, 4'd1, 4'd5, 4'd6: return K_SINGLE;
      4'd2, 4'd3, 4'd4:       return K_ALU;
`ifdef SEQ_HALT_EN
      4'd7:                   return K_HALT;
`endif
      default:                return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] single_state(input logic [3:0] o);
    case (o)
      4'd0:    return 4'b0011;
      4'd1:    return 4'b0100;
      4'd5:    return 4'b0110;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic wait_fetch(input string tag);
    int n = 0;
    while (state !== S_FETCH && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_wait_fetch"}, state, S_FETCH);
  endtask

  // Issue one instruction and walk its whole state sequence
  task automatic run_instr(input logic [15:0] ins, input string tag);
    logic [3:0] o;
    int k;
    int lat;
    exp_t e;
    o = ins[15:12];
    k = kind_of(o);
    lat = (k == K_SINGLE) ? 4 : (k == K_ALU) ? 3 + ALU_CYCLES : 3;
    if (k == K_ILL) ill_model = 1'b1;
    wait_fetch(tag);
    instr = ins;
    mem_ready = 1'b1;
    e.tag = tag; e.opc = o; e.ill = ill_model; e.due = cyc + lat;
    sb.push_back(e);
    tick();
    mem_ready = 1'b0;
    chk({tag, "_latch_state"}, state, S_LATCH);
    chk({tag, "_latch_irload"}, ir_load, 1'b1);
    chk({tag, "_latch_fetchreq"}, fetch_req, 1'b0);
    tick();
    instr = 16'($urandom);
    chk({tag, "_decode_state"}, state, S_DECODE);
    chk({tag, "_decode_opc"}, opc_q, o);
    chk({tag, "_decode_irload"}, ir_load, 1'b0);
    if (k == K_SINGLE) begin
      tick();
      chk({tag, "_exec_state"}, state, single_state(o));
      tick();
    end else if (k == K_ALU) begin
      for (int p = 0; p < ALU_CYCLES; p++) begin
        tick();
        chk({tag, "_alu_state"}, state, S_ALU);
        chk({tag, "_alu_phase"}, alu_phase, p);
        instr = 16'($urandom);
      end
      tick();
    end else if (k == K_HALT) begin
      tick();
      chk({tag, "_halt_state"}, state, S_HALT);
      chk({tag, "_halt_done"}, exec_done, 1'b1);
      for (int i = 0; i < 20; i++) begin
        mem_ready = 1'b1;
        tick();
        chk({tag, "_halt_hold_state"}, state, S_HALT);
        chk({tag, "_halt_fetchreq"}, fetch_req, 1'b0);
        chk({tag, "_halt_done_once"}, exec_done, 1'b0);
      end
      mem_ready = 1'b0;
      return;
    end else begin
      tick();
    end
    chk({tag, "_retire_state"}, state, S_RETIRE);
    chk({tag, "_retire_done"}, exec_done, 1'b1);
    chk({tag, "_retire_illegal"}, illegal, ill_model);
    chk({tag, "_retire_phase"}, alu_phase, 4'd0);
    tick();
    chk({tag, "_next_fetch"}, state, S_FETCH);
    chk({tag, "_next_done_clear"}, exec_done, 1'b0);
    chk({tag, "_opc_stable"}, opc_q, o);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    instr = '0;
    tick();
    tick();
    chk("rst_state", state, S_IDLE);
    chk("rst_opc", opc_q, 4'd0);
    chk("rst_phase", alu_phase, 4'd0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_strobes", {fetch_req, ir_load, exec_done}, 3'b000);
    reset = 1'b0;
    tick();
    chk("idle_to_fetch", state, S_FETCH);

    // Memory stall: remain in FETCH requesting
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_state", state, S_FETCH);
      chk("stall_fetchreq", fetch_req, 1'b1);
      chk("stall_irload", ir_load, 1'b0);
    end

    run_instr(16'h1234, "mov");
    run_instr(16'h2000, "add");
    run_instr(16'h0ABC, "load");
    run_instr(16'h5A5A, "ldpc");
    run_instr(16'h6123, "branch");
    run_instr(16'hF000, "ill_f");
    run_instr(16'h3000, "sub_after_ill");
    run_instr(16'h8001, "ill_8");

    // Reset mid-ALU at phase 1
    wait_fetch("rst_alu");
    instr = 16'h4000;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_alu_phase1", alu_phase, 4'd1);
    reset = 1'b1;
    tick();
    chk("rst_alu_state", state, S_IDLE);
    chk("rst_alu_phase", alu_phase, 4'd0);
    chk("rst_alu_done", exec_done, 1'b0);
    chk("rst_alu_illegal", illegal, 1'b0);
    chk("rst_alu_opc", opc_q, 4'd0);
    reset = 1'b0;
    ill_model = 1'b0;

    // Reset wins over mem_ready in FETCH
    wait_fetch("rst_prio");
    mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    chk("rst_prio_state", state, S_IDLE);
    chk("rst_prio_irload", ir_load, 1'b0);
    reset = 1'b0;
    mem_ready = 1'b0;

    run_instr(16'h4FFF, "xor");
    run_instr(16'h7000, "op7");
`ifdef SEQ_HALT_EN
    reset = 1'b1;
    tick();
    chk("halt_exit_state", state, S_IDLE);
    reset = 1'b0;
`else
    chk("op7_illegal_sticky", illegal, 1'b1);
`endif
    run_instr(16'h1000, "mov_final");

    tick();
    tick();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  INSTR_W, 16, instruction width
  OPC_W, 4, opcode field width; opcode = instr[INSTR_W-1 -: OPC_W]
  ALU_CYCLES, 3, execute cycles for ADD/SUB/XOR, legal range 1..15
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  input  1  sole clock, rising edge
  reset  input  1  synchronous, active-high reset
  instr  input  INSTR_W  instruction from memory/IR path
  mem_ready  input  1  fetch data valid this cycle
  fetch_req  output  1  fetch request to memory
  ir_load  output  1  load instruction register
  opc_q  output  OPC_W  latched opcode of current instruction
  state  output  4  current state code
  alu_phase  output  4  ALU step index, 0..ALU_CYCLES-1
  exec_done  output  1  one-cycle pulse on instruction retire
  illegal  output  1  sticky illegal-opcode flag
REQ-003 One clock; reset is synchronous and active-high; all state changes on rising clk.

Function
REQ-004 State is registered; next-state logic is combinational from registered state, opc_q, mem_ready, and alu_phase.
REQ-005 State codes: IDLE=0000, FETCH=1111, LATCH=0001, DECODE=0010, LOAD=0011, MOV=0100, ALU=0101, LDPC=0110, BRANCH=0111, RETIRE=1000, HALT=1001; all other codes go to IDLE.
REQ-006 IDLE->FETCH unconditionally on the next clock after reset release.
REQ-007 FETCH: fetch_req=1; stay while mem_ready=0; go to LATCH when mem_ready=1.
REQ-008 LATCH: ir_load=1 for exactly one cycle; opc_q captures the opcode of instr at this edge; go to DECODE.
REQ-009 DECODE dispatch on opc_q: 0000 LOAD, 0001 MOV, 0010/0011/0100 ALU, 0101 LDPC, 0110 BRANCH, 0111 HALT (only when SEQ_HALT_EN is defined), others RETIRE with illegal set to 1.
REQ-010 LOAD, MOV, LDPC, BRANCH: exactly one cycle each, then RETIRE.
REQ-011 ALU: alu_phase=0 on entry and increments each cycle; at alu_phase=ALU_CYCLES-1 go to RETIRE; alu_phase returns to 0 outside ALU.
REQ-012 RETIRE: exec_done=1 for exactly one cycle; go to FETCH.
REQ-013 Latency from mem_ready=1 in FETCH to exec_done: 4 cycles for single-cycle ops, 3+ALU_CYCLES for ALU ops, 3 for illegal opcodes.
REQ-014 fetch_req, ir_load, and exec_done are Moore outputs decoded from state only; they are never asserted together.
REQ-015 illegal stays 1 until reset; later legal instructions execute normally.
REQ-016 A change on instr outside LATCH has no effect on opc_q or on sequencing.

Reset
REQ-017 When reset=1 at a clock edge: state=IDLE, opc_q=0, alu_phase=0, illegal=0, and all strobes are 0, regardless of the current state, including mid-ALU and HALT.
REQ-018 Reset has priority over every transition, including mem_ready=1 in the same cycle.

Configuration
REQ-019 Macro SEQ_HALT_EN defined: opcode 0111 enters HALT. HALT stays in HALT with all strobes at 0, asserts exec_done once on entry, and exits only on reset.
REQ-020 SEQ_HALT_EN undefined: the HALT state is not built; opcode 0111 is illegal (RETIRE, illegal=1).

Verification
REQ-021 Reset, then instr=0x1234, mem_ready=1 held -> state sequence IDLE,FETCH,LATCH,DECODE,MOV,RETIRE,FETCH; opc_q=1; one exec_done pulse.
REQ-022 ALU_CYCLES=3, instr=0x2000 -> ALU for 3 cycles with alu_phase 0,1,2; exec_done 6 cycles after mem_ready accepted.
REQ-023 mem_ready held 0 for 5 cycles in FETCH -> fetch_req=1 and state=FETCH throughout; no ir_load.
REQ-024 instr=0xF000 -> illegal=1 and one exec_done pulse; next instr 0x3000 executes SUB with illegal still 1.
REQ-025 reset=1 asserted at alu_phase=1 -> next cycle state=IDLE, alu_phase=0, no exec_done.
REQ-026 instr=0x7000 with SEQ_HALT_EN defined -> HALT, fetch_req stays 0 for 20 cycles; without SEQ_HALT_EN -> illegal=1, then FETCH.
